// File: rtl/addr_ctrl.sv
// Command-to-adder initiator: issues one add/sub to the attached addr unit, waits for
// done under a watchdog, and returns the result (or a timeout error) on a valid/ready port.
module addr_ctrl #(
    parameter int BIT     = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [BIT-1:0]   cmd_a,
    input  logic [BIT-1:0]   cmd_b,
    input  logic             cmd_sub,
    output logic             start,
    output logic             addsub,
    output logic [BIT-1:0]   a,
    output logic [BIT-1:0]   b,
    input  logic [BIT-1:0]   sum,
    input  logic             cout,
    input  logic             done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [BIT-1:0]   res_sum,
    output logic             res_cout,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a producer holds valid and its payload steady until that edge, and never retracts.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state;
    logic [WD_W-1:0] wd;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            start     <= 1'b0;
            addsub    <= 1'b0;
            a         <= '0;
            b         <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_err   <= 1'b0;
            op_count  <= '0;
            err_count <= '0;
            wd        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a         <= cmd_a;
                        b         <= cmd_b;
                        addsub    <= cmd_sub;
                        cmd_ready <= 1'b0;
                        start     <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // done may still be high from the previous op, so it is not looked at here.
                    start <= 1'b0;
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd + WD_W'(1);
                    if (done) begin
                        res_sum   <= sum;
                        res_cout  <= cout;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wd == WD_LAST) begin
                        res_sum   <= '0;
                        res_cout  <= 1'b0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        err_count <= err_count + CNT_W'(1);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
